// File: rtl/lcd_pkg.sv
// Shared timing defaults, HD44780 command codes, FSM state encoding and the
// long-execution command detect used by the LCD bus arbiter.
package lcd_pkg;

    localparam int unsigned LCD_T_PWR   = 750000;
    localparam int unsigned LCD_T_SETUP = 5;
    localparam int unsigned LCD_T_EN    = 25;
    localparam int unsigned LCD_T_CMD   = 2500;
    localparam int unsigned LCD_T_LONG  = 82000;

    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME       = 8'h02;
    localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] LCD_CMD_LINE1      = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2      = 8'hC0;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } lcd_state_e;

    // 0x03 decodes as return-home on the controller, so it also needs the long wait.
    function automatic logic lcd_is_long(input logic rs, input logic [7:0] data);
        return !rs && (data inside {LCD_CMD_CLEAR, LCD_CMD_HOME, 8'h03});
    endfunction

    function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin winner selection with a lock owner for atomic multi-byte
// sequences; holds the priority pointer and ownership registers.
module lcd_rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         lock_i,
    input  logic                    take_i,
    output logic                    win_vld_o,
    output logic [$clog2(NREQ)-1:0] win_idx_o
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          owned_q, owned_d;

    // Descending scan so the smallest offset from the pointer is assigned last and wins.
    always_comb begin
        win_vld_o = 1'b0;
        win_idx_o = ptr_q;
        if (owned_q) begin
            win_vld_o = req_i[owner_q];
            win_idx_o = owner_q;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_i[IW'((int'(ptr_q) + k) % NREQ)]) begin
                    win_vld_o = 1'b1;
                    win_idx_o = IW'((int'(ptr_q) + k) % NREQ);
                end
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        owned_d = owned_q;
        if (take_i) begin
            if (lock_i[win_idx_o]) begin
                owned_d = 1'b1;
                owner_d = win_idx_o;
            end else begin
                owned_d = 1'b0;
                ptr_d   = (win_idx_o == IW'(NREQ - 1)) ? '0 : win_idx_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            owner_q <= '0;
            owned_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            owned_q <= owned_d;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 8-bit write bus between NREQ byte producers and times
// setup, enable pulse and execution wait with a single down-counter.
//
// state | meaning
// PWRUP | post-reset power-on wait, requests ignored
// IDLE  | bus free, grant the arbitration winner
// SETUP | rs/data stable, enable low
// PULSE | enable high
// WAIT  | enable low, controller executing the byte
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int          NREQ    = 3,
    parameter int unsigned T_PWR   = LCD_T_PWR,
    parameter int unsigned T_SETUP = LCD_T_SETUP,
    parameter int unsigned T_EN    = LCD_T_EN,
    parameter int unsigned T_CMD   = LCD_T_CMD,
    parameter int unsigned T_LONG  = LCD_T_LONG
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   req_rs_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_lock_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              busy_o,
    output logic              lcd_rs_o,
    output logic              lcd_rw_o,
    output logic              lcd_en_o,
    output logic [7:0]        lcd_data_o
);

    localparam int IW = $clog2(NREQ);
    localparam int unsigned T_MAX =
        lcd_max(lcd_max(lcd_max(T_PWR, T_SETUP), lcd_max(T_EN, T_CMD)), T_LONG);
    localparam int CW = $clog2(T_MAX + 1);

    // Counter loads hold duration-1 so the terminal count of zero is the last cycle.
    localparam logic [CW-1:0] CNT_PWR   = CW'(T_PWR - 1);
    localparam logic [CW-1:0] CNT_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] CNT_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] CNT_CMD   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CNT_LONG  = CW'(T_LONG - 1);

    lcd_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tc;

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            lcd_rs_q;
    logic [7:0]      lcd_data_q;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic          take;

    lcd_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .lock_i    (req_lock_i),
        .take_i    (take),
        .win_vld_o (win_vld),
        .win_idx_o (win_idx)
    );

    assign take  = (state_q == ST_IDLE) && win_vld;
    assign tc    = (cnt_q == '0);
    assign gnt_d = take ? (NREQ'(1) << win_idx) : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_PWRUP;
            cnt_q   <= CNT_PWR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tc ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            ST_PWRUP: if (tc) state_d = ST_IDLE;
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_SETUP;
                end
            end
            ST_SETUP: begin
                if (tc) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_EN;
                end
            end
            ST_PULSE: begin
                if (tc) begin
                    state_d = ST_WAIT;
                    cnt_d   = lcd_is_long(lcd_rs_q, lcd_data_q) ? CNT_LONG : CNT_CMD;
                end
            end
            ST_WAIT: if (tc) state_d = ST_IDLE;
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = CNT_PWR;
            end
        endcase
    end

    always_comb begin
        lcd_en_o = (state_q == ST_PULSE);
        busy_o   = (state_q != ST_IDLE);
        lcd_rw_o = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gnt_q      <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            if (take) begin
                lcd_rs_q   <= req_rs_i[win_idx];
                lcd_data_q <= req_data_i[8*win_idx +: 8];
            end
        end
    end

    assign gnt_o      = gnt_q;
    assign lcd_rs_o   = lcd_rs_q;
    assign lcd_data_o = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: expected grants are queued as requests are
// driven and matched against each gnt pulse; timing is checked cycle by cycle.
module tb_lcd_bus_arbiter;
    import lcd_pkg::*;

    localparam int NREQ    = 3;
    localparam int T_PWR   = 5;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_CMD   = 4;
    localparam int T_LONG  = 10;
    localparam int T_BYTE      = T_SETUP + T_EN + T_CMD + 1;
    localparam int T_BYTE_LONG = T_SETUP + T_EN + T_LONG + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  req_rs = '0;
    logic [2:0]  req_lock = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  gnt;
    logic        busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0]  lcd_data;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .NREQ(NREQ), .T_PWR(T_PWR), .T_SETUP(T_SETUP),
        .T_EN(T_EN), .T_CMD(T_CMD), .T_LONG(T_LONG)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_i      (req),
        .req_rs_i   (req_rs),
        .req_data_i (req_data),
        .req_lock_i (req_lock),
        .gnt_o      (gnt),
        .busy_o     (busy),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_en_o   (lcd_en),
        .lcd_data_o (lcd_data)
    );

    typedef struct packed {
        logic [2:0] gnt;
        logic       rs;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int         who;
        logic       rs;
        logic [7:0] d;
        int         idle;
    } lt_t;

    lt_t long_tbl [6] = '{
        '{0, 1'b0, LCD_CMD_CLEAR,    T_BYTE_LONG - 1},
        '{0, 1'b0, LCD_CMD_FUNC_SET, T_BYTE - 1},
        '{1, 1'b0, 8'h03,            T_BYTE_LONG - 1},
        '{1, 1'b0, 8'h04,            T_BYTE - 1},
        '{2, 1'b1, 8'h01,            T_BYTE - 1},
        '{2, 1'b0, LCD_CMD_HOME,     T_BYTE_LONG - 1}
    };

    exp_t exp_q[$];
    exp_t e_mon;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic rs, input logic [7:0] d, input logic lk);
        req[i]             = 1'b1;
        req_rs[i]          = rs;
        req_data[8*i +: 8] = d;
        req_lock[i]        = lk;
    endtask

    task automatic expect_gnt(input int i, input logic rs, input logic [7:0] d);
        exp_t e;
        e.gnt  = 3'(1 << i);
        e.rs   = rs;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 200);
    endtask

    task automatic measure_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Scoreboard side: every gnt pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en && gnt != '0) begin
            if (exp_q.size() == 0) begin
                check("gnt_unexpected", 32'(gnt), 0);
            end else begin
                e_mon = exp_q.pop_front();
                check("gnt", 32'(gnt), 32'(e_mon.gnt));
                check("lcd_rs", 32'(lcd_rs), 32'(e_mon.rs));
                check("lcd_data", 32'(lcd_data), 32'(e_mon.data));
                check("lcd_rw", 32'(lcd_rw), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;

        reset = 1'b1;
        set_req(0, 1'b0, LCD_CMD_FUNC_SET, 1'b0);
        set_req(1, 1'b1, 8'h41, 1'b0);
        set_req(2, 1'b1, 8'h42, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_en", 32'(lcd_en), 0);
        check("rst_rs", 32'(lcd_rs), 0);
        check("rst_rw", 32'(lcd_rw), 0);
        check("rst_data", 32'(lcd_data), 0);

        // Power-up: all three requesting from reset release
        mon_en = 1'b1;
        expect_gnt(0, 1'b0, LCD_CMD_FUNC_SET);
        reset = 1'b0;
        for (int k = 0; k < T_PWR; k++) begin
            @(negedge clk);
            check("pwrup_gnt", 32'(gnt), 0);
            check("pwrup_en", 32'(lcd_en), 0);
            check("pwrup_data", 32'(lcd_data), 0);
            check("pwrup_busy", 32'(busy), 32'(k < T_PWR - 1));
        end
        wait_gnt(n);
        check("pwrup_first_lat", n, 1);
        req = '0;
        measure_idle(n);
        check("pwrup_idle", n, T_BYTE - 1);

        // Single character with full cycle-by-cycle timing
        set_req(1, 1'b1, 8'h41, 1'b0);
        expect_gnt(1, 1'b1, 8'h41);
        wait_gnt(n);
        check("char_lat", n, 1);
        req = '0;
        for (int k = 1; k <= T_BYTE; k++) begin
            check("char_en", 32'(lcd_en), 32'(k > T_SETUP && k <= T_SETUP + T_EN));
            check("char_busy", 32'(busy), 32'(k < T_BYTE));
            check("char_gnt_pulse", 32'(gnt != '0), 32'(k == 1));
            check("char_data_hold", 32'(lcd_data), 32'h41);
            if (k < T_BYTE) @(negedge clk);
        end

        // Long/short execution-wait boundaries
        for (int t = 0; t < 6; t++) begin
            set_req(long_tbl[t].who, long_tbl[t].rs, long_tbl[t].d, 1'b0);
            expect_gnt(long_tbl[t].who, long_tbl[t].rs, long_tbl[t].d);
            wait_gnt(n);
            check("wait_lat", n, 1);
            req = '0;
            measure_idle(n);
            check("wait_len", n, long_tbl[t].idle);
        end

        // Round-robin with all requesters held (pointer is 0 after granting 2)
        set_req(0, 1'b1, 8'h30, 1'b0);
        set_req(1, 1'b1, 8'h31, 1'b0);
        set_req(2, 1'b1, 8'h32, 1'b0);
        for (int r = 0; r < 6; r++) expect_gnt(r % 3, 1'b1, 8'(8'h30 + r % 3));
        for (int r = 0; r < 6; r++) begin
            wait_gnt(n);
            check("rr_interval", n, (r == 0) ? 1 : T_BYTE);
        end
        req = '0;
        measure_idle(n);
        check("rr_idle", n, T_BYTE - 1);

        // One grant to 1 moves the pointer to 2
        set_req(1, 1'b0, LCD_CMD_DISP_ON, 1'b0);
        expect_gnt(1, 1'b0, LCD_CMD_DISP_ON);
        wait_gnt(n);
        check("pre_lock_lat", n, 1);
        req = '0;
        measure_idle(n);

        // Locked three-byte sequence from requester 2 while 0 and 1 compete
        set_req(0, 1'b1, 8'h50, 1'b0);
        set_req(1, 1'b1, 8'h51, 1'b0);
        set_req(2, 1'b0, LCD_CMD_LINE2, 1'b1);
        expect_gnt(2, 1'b0, LCD_CMD_LINE2);
        wait_gnt(n);
        check("lock1_lat", n, 1);
        set_req(2, 1'b1, 8'h48, 1'b1);
        expect_gnt(2, 1'b1, 8'h48);
        wait_gnt(n);
        check("lock2_interval", n, T_BYTE);
        req[2] = 1'b0;
        seen = 0;
        repeat (3 * T_BYTE) begin
            @(negedge clk);
            if (gnt != '0) seen++;
        end
        check("lock_hold_gnt", seen, 0);
        check("lock_hold_idle", 32'(busy), 0);
        set_req(2, 1'b1, 8'h49, 1'b0);
        expect_gnt(2, 1'b1, 8'h49);
        wait_gnt(n);
        check("lock3_lat", n, 1);
        req[2] = 1'b0;
        expect_gnt(0, 1'b1, 8'h50);
        wait_gnt(n);
        check("unlock_next", n, T_BYTE);
        req[0] = 1'b0;
        expect_gnt(1, 1'b1, 8'h51);
        wait_gnt(n);
        check("unlock_after", n, T_BYTE);
        req = '0;
        measure_idle(n);

        // Reset during PULSE while requester 2 holds a lock
        set_req(2, 1'b0, LCD_CMD_ENTRY_MODE, 1'b1);
        expect_gnt(2, 1'b0, LCD_CMD_ENTRY_MODE);
        wait_gnt(n);
        check("rstp_lat", n, 1);
        n = 0;
        while (!lcd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstp_pulse_reached", n, T_SETUP);
        set_req(0, 1'b1, 8'h60, 1'b0);
        set_req(1, 1'b1, 8'h61, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstp_en", 32'(lcd_en), 0);
        check("rstp_busy", 32'(busy), 1);
        check("rstp_gnt", 32'(gnt), 0);
        check("rstp_data", 32'(lcd_data), 0);
        expect_gnt(0, 1'b1, 8'h60);
        wait_gnt(n);
        check("rstp_regrant_lat", n, T_PWR + 1);
        req = '0;
        measure_idle(n);
        check("rstp_idle", n, T_BYTE - 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
